// File: rtl/iqft3_seq.sv
// iqft3_seq: sequential 3-qubit inverse QFT over an 8-entry complex register file.
// One shared Hadamard butterfly and one shared rotation unit, one step per clock.
module iqft3_seq #(
    parameter int TOTAL_WIDTH = 16,
    parameter int FRAC_WIDTH  = 14,
    parameter int INV_SQRT2   = 11585
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] i000_r, i000_i, i001_r, i001_i,
    input  logic [TOTAL_WIDTH-1:0] i010_r, i010_i, i011_r, i011_i,
    input  logic [TOTAL_WIDTH-1:0] i100_r, i100_i, i101_r, i101_i,
    input  logic [TOTAL_WIDTH-1:0] i110_r, i110_i, i111_r, i111_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] f000_r, f000_i, f001_r, f001_i,
    output logic [TOTAL_WIDTH-1:0] f010_r, f010_i, f011_r, f011_i,
    output logic [TOTAL_WIDTH-1:0] f100_r, f100_i, f101_r, f101_i,
    output logic [TOTAL_WIDTH-1:0] f110_r, f110_i, f111_r, f111_i,
    output logic                   busy,
    output logic                   sat_flag
);
    localparam int unsigned TW = TOTAL_WIDTH;
    localparam int unsigned SW = TW + 1;
    localparam int unsigned PW = SW + TW;
    localparam logic signed [PW-1:0] MAX_P = PW'((2 ** (TW - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_P = -MAX_P - PW'(1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SWAP = 4'd1;
    localparam logic [3:0] S_H0   = 4'd2;
    localparam logic [3:0] S_R2A  = 4'd3;
    localparam logic [3:0] S_H1   = 4'd4;
    localparam logic [3:0] S_R4   = 4'd5;
    localparam logic [3:0] S_R2B  = 4'd6;
    localparam logic [3:0] S_H2   = 4'd7;
    localparam logic [3:0] S_OUT  = 4'd8;

    // Scale by 1/sqrt(2): full-width product, floor shift.
    function automatic logic signed [PW-1:0] scale(input logic signed [SW-1:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * PW'(INV_SQRT2);
        return p >>> FRAC_WIDTH;
    endfunction

    function automatic logic clips(input logic signed [PW-1:0] x);
        return (x > MAX_P) || (x < MIN_P);
    endfunction

    function automatic logic signed [TW-1:0] clamp(input logic signed [PW-1:0] x);
        if (x > MAX_P) return TW'(MAX_P);
        if (x < MIN_P) return TW'(MIN_P);
        return TW'(x);
    endfunction

    logic [3:0] state, state_n;
    logic [1:0] step, step_n;
    logic [2:0] ia, ib;

    logic signed [TW-1:0] rf_r [8];
    logic signed [TW-1:0] rf_i [8];
    logic signed [TW-1:0] rf_r_n [8];
    logic signed [TW-1:0] rf_i_n [8];
    logic signed [TW-1:0] in_r [8];
    logic signed [TW-1:0] in_i [8];
    logic [TW-1:0]        f_r [8];
    logic [TW-1:0]        f_i [8];
    logic                 sat_c;
    logic                 load;

    logic signed [TW-1:0] op_ar, op_ai, op_br, op_bi;
    logic signed [PW-1:0] h_ar_w, h_ai_w, h_br_w, h_bi_w, r4_r_w, r4_i_w, r2_i_w;
    logic signed [SW-1:0] neg_ar;

    assign in_r = '{i000_r, i001_r, i010_r, i011_r, i100_r, i101_r, i110_r, i111_r};
    assign in_i = '{i000_i, i001_i, i010_i, i011_i, i100_i, i101_i, i110_i, i111_i};

    assign {f000_r, f001_r, f010_r, f011_r, f100_r, f101_r, f110_r, f111_r} =
           {f_r[0], f_r[1], f_r[2], f_r[3], f_r[4], f_r[5], f_r[6], f_r[7]};
    assign {f000_i, f001_i, f010_i, f011_i, f100_i, f101_i, f110_i, f111_i} =
           {f_i[0], f_i[1], f_i[2], f_i[3], f_i[4], f_i[5], f_i[6], f_i[7]};

    assign load = (state == S_IDLE) && in_valid;

    // State and step-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            step  <= 2'd0;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    // Next state, step sequencing and operand index decode.
    always_comb begin
        state_n = state;
        step_n  = step;
        ia      = 3'd0;
        ib      = 3'd0;
        case (state)
            S_IDLE: if (in_valid) begin state_n = S_SWAP; step_n = 2'd0; end
            S_SWAP: state_n = S_H0;
            S_H0: begin
                ia = {step, 1'b0};
                ib = {step, 1'b1};
                if (step == 2'd3) begin state_n = S_R2A; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_R2A: begin
                ia = {step[0], 2'b11};
                if (step == 2'd1) begin state_n = S_H1; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_H1: begin
                ia = {step[1], 1'b0, step[0]};
                ib = {step[1], 1'b1, step[0]};
                if (step == 2'd3) begin state_n = S_R4; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_R4: begin
                ia = {1'b1, step[0], 1'b1};
                if (step == 2'd1) begin state_n = S_R2B; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_R2B: begin
                ia = {2'b11, step[0]};
                if (step == 2'd1) begin state_n = S_H2; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_H2: begin
                ia = {1'b0, step};
                ib = {1'b1, step};
                if (step == 2'd3) begin state_n = S_OUT; step_n = 2'd0; end
                else step_n = step + 2'd1;
            end
            S_OUT: if (out_ready) state_n = S_IDLE;
            default: begin state_n = S_IDLE; step_n = 2'd0; end
        endcase
    end

    // Shared butterfly and rotation arithmetic on the selected operands.
    always_comb begin
        op_ar  = rf_r[ia];
        op_ai  = rf_i[ia];
        op_br  = rf_r[ib];
        op_bi  = rf_i[ib];
        h_ar_w = scale(SW'(op_ar) + SW'(op_br));
        h_ai_w = scale(SW'(op_ai) + SW'(op_bi));
        h_br_w = scale(SW'(op_ar) - SW'(op_br));
        h_bi_w = scale(SW'(op_ai) - SW'(op_bi));
        r4_r_w = scale(SW'(op_ar) + SW'(op_ai));
        r4_i_w = scale(SW'(op_ai) - SW'(op_ar));
        neg_ar = -SW'(op_ar);
        r2_i_w = PW'(neg_ar);
    end

    // Register-file update for the current step, plus step saturation.
    always_comb begin
        rf_r_n = rf_r;
        rf_i_n = rf_i;
        sat_c  = 1'b0;
        case (state)
            S_SWAP: begin
                rf_r_n[1] = rf_r[4]; rf_r_n[4] = rf_r[1];
                rf_i_n[1] = rf_i[4]; rf_i_n[4] = rf_i[1];
                rf_r_n[3] = rf_r[6]; rf_r_n[6] = rf_r[3];
                rf_i_n[3] = rf_i[6]; rf_i_n[6] = rf_i[3];
            end
            S_H0, S_H1, S_H2: begin
                rf_r_n[ia] = clamp(h_ar_w);
                rf_i_n[ia] = clamp(h_ai_w);
                rf_r_n[ib] = clamp(h_br_w);
                rf_i_n[ib] = clamp(h_bi_w);
                sat_c = clips(h_ar_w) | clips(h_ai_w) | clips(h_br_w) | clips(h_bi_w);
            end
            S_R2A, S_R2B: begin
                rf_r_n[ia] = op_ai;
                rf_i_n[ia] = clamp(r2_i_w);
                sat_c = clips(r2_i_w);
            end
            S_R4: begin
                rf_r_n[ia] = clamp(r4_r_w);
                rf_i_n[ia] = clamp(r4_i_w);
                sat_c = clips(r4_r_w) | clips(r4_i_w);
            end
            default: ;
        endcase
    end

    // Register file, result outputs and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                rf_r[k] <= '0;
                rf_i[k] <= '0;
                f_r[k]  <= '0;
                f_i[k]  <= '0;
            end
            sat_flag <= 1'b0;
        end else if (load) begin
            rf_r     <= in_r;
            rf_i     <= in_i;
            sat_flag <= 1'b0;
        end else if (state != S_IDLE && state != S_OUT) begin
            rf_r     <= rf_r_n;
            rf_i     <= rf_i_n;
            sat_flag <= sat_flag | sat_c;
            if (state == S_H2 && step == 2'd3) begin
                for (int k = 0; k < 8; k++) begin
                    f_r[k] <= rf_r_n[k];
                    f_i[k] <= rf_i_n[k];
                end
            end
        end
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            out_valid <= (state_n == S_OUT);
            in_ready  <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE) && (state_n != S_OUT);
        end
    end
endmodule

// File: tb/tb_iqft3_seq.sv
// Directed testbench for iqft3_seq with hand-computed expected vectors.
module tb_iqft3_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, busy, sat_flag;
    logic signed [15:0] vr [8];
    logic signed [15:0] vi [8];
    logic [15:0] fr [8];
    logic [15:0] fi [8];
    logic signed [15:0] er [8];
    logic signed [15:0] ei [8];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    iqft3_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i000_r(vr[0]), .i000_i(vi[0]), .i001_r(vr[1]), .i001_i(vi[1]),
        .i010_r(vr[2]), .i010_i(vi[2]), .i011_r(vr[3]), .i011_i(vi[3]),
        .i100_r(vr[4]), .i100_i(vi[4]), .i101_r(vr[5]), .i101_i(vi[5]),
        .i110_r(vr[6]), .i110_i(vi[6]), .i111_r(vr[7]), .i111_i(vi[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .f000_r(fr[0]), .f000_i(fi[0]), .f001_r(fr[1]), .f001_i(fi[1]),
        .f010_r(fr[2]), .f010_i(fi[2]), .f011_r(fr[3]), .f011_i(fi[3]),
        .f100_r(fr[4]), .f100_i(fi[4]), .f101_r(fr[5]), .f101_i(fi[5]),
        .f110_r(fr[6]), .f110_i(fi[6]), .f111_r(fr[7]), .f111_i(fi[7]),
        .busy(busy), .sat_flag(sat_flag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec;
        for (int k = 0; k < 8; k++) begin
            vr[k] = 16'sd0;
            vi[k] = 16'sd0;
        end
    endtask

    task automatic do_load;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset sat_flag got %b want 0", sat_flag); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== 16'd0 || fi[k] !== 16'd0) begin
                fails++; $display("FAIL reset f[%0d] got (%0d,%0d) want (0,0)", k, $signed(fr[k]), $signed(fi[k]));
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basis0;
        int n;
        clear_vec(); vr[0] = 16'sd16384;
        do_load();
        wait_out(n);
        tests++; if (n != 19) begin fails++; $display("FAIL basis0 latency got %0d want 19", n); end
        tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL basis0 out-state busy/in_ready got %b/%b want 0/0", busy, in_ready); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL basis0 sat_flag got %b want 0", sat_flag); end
        for (int k = 0; k < 8; k++) begin
            tests++; if ($signed(fr[k]) != 5791 || $signed(fi[k]) != 0) begin
                fails++; $display("FAIL basis0 f[%0d] got (%0d,%0d) want (5791,0)", k, $signed(fr[k]), $signed(fi[k]));
            end
        end
        tick();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basis0 return out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_basis1;
        int n;
        clear_vec(); vr[1] = 16'sd16384;
        er = '{16'sd5791, 16'sd4094, 16'sd0, -16'sd4096, -16'sd5792, -16'sd4095, 16'sd0, 16'sd4095};
        ei = '{16'sd0, -16'sd4096, -16'sd5792, -16'sd4095, 16'sd0, 16'sd4095, 16'sd5791, 16'sd4094};
        do_load();
        wait_out(n);
        tests++; if (n != 19) begin fails++; $display("FAIL basis1 latency got %0d want 19", n); end
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL basis1 sat_flag got %b want 0", sat_flag); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== er[k] || fi[k] !== ei[k]) begin
                fails++; $display("FAIL basis1 f[%0d] got (%0d,%0d) want (%0d,%0d)", k, $signed(fr[k]), $signed(fi[k]), er[k], ei[k]);
            end
        end
        tick();
    endtask

    task automatic test_rot_minus_i;
        int n;
        clear_vec(); vr[6] = 16'sd16384;
        er = '{16'sd5791, 16'sd0, -16'sd5793, 16'sd0, 16'sd5791, 16'sd0, -16'sd5793, 16'sd0};
        ei = '{16'sd0, 16'sd5791, 16'sd0, -16'sd5793, 16'sd0, 16'sd5791, 16'sd0, -16'sd5793};
        do_load();
        wait_out(n);
        tests++; if (n != 19) begin fails++; $display("FAIL rot latency got %0d want 19", n); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== er[k] || fi[k] !== ei[k]) begin
                fails++; $display("FAIL rot f[%0d] got (%0d,%0d) want (%0d,%0d)", k, $signed(fr[k]), $signed(fi[k]), er[k], ei[k]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure;
        int n;
        clear_vec(); vr[0] = 16'sd16384;
        out_ready = 1'b0;
        do_load();
        wait_out(n);
        tests++; if (n != 19) begin fails++; $display("FAIL bp latency got %0d want 19", n); end
        vr[1] = 16'sd1000;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            tick();
            tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp hold cycle %0d out_valid/in_ready got %b/%b want 1/0", c, out_valid, in_ready);
            end
            tests++; if ($signed(fr[0]) != 5791 || $signed(fr[7]) != 5791 || fi[3] !== 16'd0) begin
                fails++; $display("FAIL bp stable cycle %0d f0_r=%0d f7_r=%0d f3_i=%0d want 5791,5791,0", c, $signed(fr[0]), $signed(fr[7]), $signed(fi[3]));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp release out_valid/in_ready got %b/%b want 0/1", out_valid, in_ready); end
        tests++; if ($signed(fr[0]) != 5791) begin fails++; $display("FAIL bp keep f0_r got %0d want 5791", $signed(fr[0])); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp no-capture busy got %b want 0", busy); end
    endtask

    task automatic test_ignored_input;
        int bad_busy = 0;
        clear_vec(); vr[1] = 16'sd16384;
        er = '{16'sd5791, 16'sd4094, 16'sd0, -16'sd4096, -16'sd5792, -16'sd4095, 16'sd0, 16'sd4095};
        ei = '{16'sd0, -16'sd4096, -16'sd5792, -16'sd4095, 16'sd0, 16'sd4095, 16'sd5791, 16'sd4094};
        do_load();
        if (busy !== 1'b1) bad_busy++;
        for (int t = 1; t <= 18; t++) begin
            if (t == 3) begin clear_vec(); vr[0] = 16'sd16384; vi[5] = 16'sd3000; end
            in_valid = (t >= 3 && t <= 15);
            tick();
            if (busy !== 1'b1) bad_busy++;
        end
        in_valid = 1'b0;
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL ignore busy dropped %0d times want 0", bad_busy); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ignore out_valid at edge 19 got %b want 1", out_valid); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== er[k] || fi[k] !== ei[k]) begin
                fails++; $display("FAIL ignore f[%0d] got (%0d,%0d) want (%0d,%0d)", k, $signed(fr[k]), $signed(fi[k]), er[k], ei[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_midjob;
        int seen = 0;
        clear_vec(); vr[0] = 16'sd16384;
        do_load();
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL midreset flags out_valid/busy/in_ready got %b/%b/%b want 0/0/1", out_valid, busy, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== 16'd0 || fi[k] !== 16'd0) begin
                fails++; $display("FAIL midreset f[%0d] got (%0d,%0d) want (0,0)", k, $signed(fr[k]), $signed(fi[k]));
            end
        end
        tick();
        rst_n = 1'b1;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midreset spurious out_valid got %0d want 0", seen); end
    endtask

    task automatic test_saturation;
        int n;
        clear_vec(); vr[0] = 16'sd32767; vr[4] = 16'sd32767;
        er = '{16'sd16382, 16'sd0, 16'sd16382, 16'sd0, 16'sd16382, 16'sd0, 16'sd16382, 16'sd0};
        do_load();
        wait_out(n);
        tests++; if (n != 19) begin fails++; $display("FAIL sat latency got %0d want 19", n); end
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat sat_flag got %b want 1", sat_flag); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (fr[k] !== er[k] || fi[k] !== 16'd0) begin
                fails++; $display("FAIL sat f[%0d] got (%0d,%0d) want (%0d,0)", k, $signed(fr[k]), $signed(fi[k]), er[k]);
            end
        end
        tick();
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat sticky in idle got %b want 1", sat_flag); end
        clear_vec(); vr[0] = 16'sd16384;
        do_load();
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL sat clear on load got %b want 0", sat_flag); end
        wait_out(n);
        tests++; if (n != 19 || sat_flag !== 1'b0) begin fails++; $display("FAIL sat followup latency/sat got %0d/%b want 19/0", n, sat_flag); end
        tick();
    endtask

    initial begin
        clear_vec();
        repeat (2) tick();
        test_reset();
        test_basis0();
        test_basis1();
        test_rot_minus_i();
        test_backpressure();
        test_ignored_input();
        test_reset_midjob();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iqft3_seq.md
Name: iqft3_seq

Overview:
- Sequential, area-lean 3-qubit inverse QFT. It accepts an 8-amplitude complex state vector in signed fixed point, applies the inverse of the forward QFT circuit, and returns the resulting vector.
- One shared Hadamard butterfly and one shared conditional-rotation unit are time-multiplexed over an 8-entry register file under FSM control.
- Sits downstream of the pipelined forward QFT. It recovers basis states for verification loopback and for phase-estimation readout.

Parameters:
- TOTAL_WIDTH, default `TOTAL_WIDTH (16): amplitude width, two's complement.
- FRAC_WIDTH, default `FRAC_WIDTH (14): fractional bits (Q2.14 by default).
- INV_SQRT2, default 11585: round(2^FRAC_WIDTH/sqrt(2)).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block idle, can accept
- i000_r..i111_i  in  16 x TOTAL_WIDTH  input amplitudes, real/imag, basis 000..111
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- f000_r..f111_i  out  16 x TOTAL_WIDTH  result amplitudes, registered
- busy  out  1  computing (not IDLE, not OUT)
- sat_flag  out  1  sticky: a saturation occurred in the current job

Behaviour:
- Reset (async, rst_n=0): state=IDLE; register file, f* outputs, sat_flag, step counter = 0; out_valid=0, busy=0. Reset mid-job aborts the job immediately, with no output.
- Outputs in IDLE: in_ready=1, busy=0.
- Load: edge with in_valid&&in_ready captures all 16 inputs into reg a[0..7], clears sat_flag, enters SWAP. Index = basis bits q2q1q0.
- Ignored input: in_valid while busy or in OUT is ignored. No capture, no error.
- FSM, one step per clock:
  - SWAP (1): exchange a1<->a4, a3<->a6.
  - H0 (4): pairs (0,1),(2,3),(4,5),(6,7).
  - R2A (2): a3, a7.
  - H1 (4): pairs (0,2),(1,3),(4,6),(5,7).
  - R4 (2): a5, a7.
  - R2B (2): a6, a7.
  - H2 (4): pairs (0,4),(1,5),(2,6),(3,7).
  - OUT.
  - Pair/element order within a phase is as listed.
- Latency: out_valid rises 19 edges after the load edge. f* update on that same edge, from the register file.
- Hadamard step (pair a,b), per real/imag component:
  - a' = sat(((a+b)*INV_SQRT2) >>> FRAC_WIDTH)
  - b' = sat(((a-b)*INV_SQRT2) >>> FRAC_WIDTH)
  - Sum/difference computed at TOTAL_WIDTH+1 bits; full-width product; arithmetic shift (floor).
- Rotation R2A/R2B (multiply by -i): (r,i) -> (i, sat(-r)). sat(-MIN) = MAX.
- Rotation R4 (multiply by e^-i*pi/4):
  - r' = sat(((r+i)*INV_SQRT2) >>> FRAC_WIDTH)
  - i' = sat(((i-r)*INV_SQRT2) >>> FRAC_WIDTH)
- Saturation: sat() clamps to [-2^(TW-1), 2^(TW-1)-1]. Any clamp sets sat_flag, which holds until the next load or reset.
- OUT state: out_valid=1; f* and sat_flag stable. The edge with out_ready=1 returns to IDLE and drops out_valid. f* keep their last value, they are not cleared. in_ready is 0 in OUT; a load is possible from the first IDLE cycle.
- out_ready=1 held continuously: OUT lasts exactly one cycle.

Test Plan:
- i000_r=16384, all other inputs 0 -> after 19 edges out_valid=1; all eight f*_r=5791, all f*_i=0; sat_flag=0.
- i001_r=16384, all other inputs 0 -> f000=(5791,0), f100=(-5792,0), f010=(0,-5792), f110=(0,5791); sat_flag=0.
- i000_r=i100_r=32767, all other inputs 0 -> sat_flag=1; f000_r=f010_r=f100_r=f110_r=16382; all other outputs 0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_valid and f* stay stable; in_ready=0; in_valid pulses are ignored. out_ready=1 for one edge -> IDLE, in_ready=1.
- Pulse in_valid with a different vector during cycles 3..15 of a job -> result equals the first vector's result; busy=1 throughout the job.
- Assert rst_n=0 at cycle 8 of a job -> out_valid=0 and f*=0 immediately; no out_valid follows. A new load completes normally.
